// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed seven-segment scan driver.
//
// Contents
//   seg_t       : 7-bit segment vector {a,b,c,d,e,f,g}, a at bit 6, active-low
//   SEG_OFF     : all segments dark
//   SEG_LUT     : hex nibble to active-low segment pattern, entry 0 at index 0
//   seg_decode  : table lookup helper used by the decoder
// ---------------------------------------------------------------------------
package seg7_pkg;

  // Segment vector type, bit 6 is segment a and bit 0 is segment g.
  typedef logic [6:0] seg_t;

  // Every segment off (active-low outputs, so all ones).
  localparam seg_t SEG_OFF = 7'b1111111;

  // Hex character table. The concatenation is written from F down to 0 so
  // that SEG_LUT[n] selects the pattern for nibble n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Look up the active-low pattern for one hex nibble.
  function automatic seg_t seg_decode(input logic [3:0] nibble);
    return SEG_LUT[nibble];
  endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// ---------------------------------------------------------------------------
// hex7seg_dec
// Pure combinational hex-to-seven-segment decoder built on SEG_LUT.
//
// Ports
//   nibble_i : 4-bit hex digit to display
//   seg_o    : active-low segment pattern {a,b,c,d,e,f,g}
// ---------------------------------------------------------------------------
module hex7seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  // The whole decoder is a single table lookup; no state is held here.
  assign seg_o = seg_decode(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for NUM_DIGITS common-anode/cathode seven-segment
// digits. Each digit owns a slot of SCAN_DIV clocks; the first BLANK_CYC
// clocks of every slot are dark to stop the previous digit ghosting into the
// next one. New content is loaded into a staging register at any time and is
// only copied to the displayed (shadow) register at a frame boundary, so a
// frame never shows a mix of old and new nibbles.
//
// Parameters
//   NUM_DIGITS    : number of digits, 1..8
//   SCAN_DIV      : clocks per digit slot, at least 2
//   BLANK_CYC     : dark clocks at the start of each slot, 0..SCAN_DIV-1
//   AN_ACTIVE_LOW : 1 = anode enables are active-low
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   value       : hex nibbles, nibble i drives digit i (digit 0 is LSD)
//   dp_in       : decimal point request per digit, 1 = lit
//   blank_en    : force digit dark, 1 = blank
//   lz_suppress : leading-zero suppression enable, used live
//   load        : one-clock strobe capturing value, dp_in and blank_en
//   seg         : registered active-low segments {a..g}
//   dp          : registered active-low decimal point
//   an          : registered digit enables
//   frame_done  : high for the single clock that ends each frame
// ---------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int BLANK_CYC     = 16,
  parameter bit AN_ACTIVE_LOW = 1'b1
)
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_en,
  input  logic                    lz_suppress,
  input  logic                    load,
  output seg_t                    seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      BLANK_LIM = CNT_W'(BLANK_CYC);
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // Scan position
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Staging copy of the last load, and whether it still has to be shown
  logic [4*NUM_DIGITS-1:0] stg_val_q, stg_val_d;
  logic [NUM_DIGITS-1:0]   stg_dp_q, stg_dp_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d;
  logic                    pending_q, pending_d;

  // Shadow copy: the content actually on the display this frame
  logic [4*NUM_DIGITS-1:0] shd_val_q, shd_val_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [NUM_DIGITS-1:0]   shd_blank_q, shd_blank_d;

  // Registered display outputs
  seg_t                  seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Combinational helpers
  logic                  frame_end;
  logic                  in_blank;
  logic [NUM_DIGITS-1:0] supp;
  logic                  zero_run;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  cur_supp;
  seg_t                  cur_seg;

  // The frame ends on the last clock of the last digit's slot. frame_done is
  // taken straight from the registered scan position so that a load issued in
  // the same clock can be recognised as coinciding with the boundary.
  assign frame_end  = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
  assign frame_done = frame_end;
  assign in_blank   = (cnt_q < BLANK_LIM);

  // Slot counter wraps every SCAN_DIV clocks and then steps the digit index,
  // which itself wraps after the last digit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (idx_q == IDX_MAX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Double buffering. A load always refreshes staging and raises pending, so
  // repeated loads within a frame simply overwrite each other. At the frame
  // boundary the shadow takes either the live inputs (a load landing exactly
  // on the boundary) or the staged copy, and pending drops in both cases.
  always_comb begin
    stg_val_d   = stg_val_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    pending_d   = pending_q;
    shd_val_d   = shd_val_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    if (load) begin
      stg_val_d   = value;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_en;
      pending_d   = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        shd_val_d   = value;
        shd_dp_d    = dp_in;
        shd_blank_d = blank_en;
        pending_d   = 1'b0;
      end else if (pending_q) begin
        shd_val_d   = stg_val_q;
        shd_dp_d    = stg_dp_q;
        shd_blank_d = stg_blank_q;
        pending_d   = 1'b0;
      end
    end
  end

  // Leading-zero suppression walks from the most significant digit down and
  // keeps a running "everything above and including me is zero" flag. Digit 0
  // is never suppressed so a value of zero still shows a single 0.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (shd_val_q[4*i +: 4] == 4'h0);
      if (i != 0) begin
        supp[i] = lz_suppress & zero_run;
      end
    end
  end

  // Pick out the shadow fields for the digit currently being scanned.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_supp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = shd_val_q[4*i +: 4];
        cur_dp    = shd_dp_q[i];
        cur_blank = shd_blank_q[i];
        cur_supp  = supp[i];
      end
    end
  end

  hex7seg_dec u_dec (
    .nibble_i (cur_nib),
    .seg_o    (cur_seg)
  );

  // Output selection. During the dead time everything is dark. Otherwise the
  // current digit's anode is enabled; a blanked digit kills both segments and
  // dp, whereas a suppressed digit only kills the segments so a requested
  // decimal point still lights.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    if (!in_blank) begin
      an_d = AN_OFF ^ (NUM_DIGITS'(1) << idx_q);
      if (!cur_blank) begin
        seg_d = cur_supp ? SEG_OFF : cur_seg;
        dp_d  = ~cur_dp;
      end
    end
  end

  // All state, including the output registers, resets asynchronously so the
  // display goes dark the moment rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      stg_val_q   <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '0;
      pending_q   <= 1'b0;
      shd_val_q   <= '0;
      shd_dp_q    <= '0;
      shd_blank_q <= '0;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
      an_q        <= AN_OFF;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stg_val_q   <= stg_val_d;
      stg_dp_q    <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      pending_q   <= pending_d;
      shd_val_q   <= shd_val_d;
      shd_dp_q    <= shd_dp_d;
      shd_blank_q <= shd_blank_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with 4 digits, 4-clock slots and
// one dead clock per slot. Expected slot observations are pushed to a queue
// when content is loaded and popped one per clock while the frame plays out.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;
  import seg7_pkg::*;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dpIn;
  logic [3:0]  blankEn;
  logic        lzSuppress;
  logic        load;
  seg_t        seg;
  logic        dp;
  logic [3:0]  an;
  logic        frameDone;

  // One observation of the display outputs
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } obs_t;

  // One table vector: inputs plus expected per-digit segments and dp
  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      dpIn;
    logic [3:0]      blankEn;
    logic            lz;
    logic [3:0][6:0] expSeg;
    logic [3:0]      expDp;
  } vec_t;

  obs_t expQ[$];
  vec_t vecs [9];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SD),
    .BLANK_CYC     (BC),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_in       (dpIn),
    .blank_en    (blankEn),
    .lz_suppress (lzSuppress),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frameDone)
  );

  // Safety net in case the design never produces the expected events
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  // Compare one value and count it
  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Queue the 16 observations of one full frame
  task automatic pushFrame(input logic [3:0][6:0] segs, input logic [3:0] dps);
    obs_t       e;
    logic [3:0] anExp;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < SD; c++) begin
        anExp    = 4'b1111;
        anExp[d] = 1'b0;
        if (c < BC) e = {4'b1111, SEG_OFF, 1'b1};
        else        e = {anExp, segs[d], dps[d]};
        expQ.push_back(e);
      end
    end
  endtask

  // Drive one vector with a single load strobe and queue what it should show
  task automatic applyStimulus(input vec_t v);
    value      = v.value;
    dpIn       = v.dpIn;
    blankEn    = v.blankEn;
    lzSuppress = v.lz;
    load       = 1'b1;
    @(posedge clk); #1;
    load       = 1'b0;
    pushFrame(v.expSeg, v.expDp);
  endtask

  // Wait (bounded) until frame_done is high in the current clock
  task automatic waitFrameDone();
    int n = 0;
    while (frameDone !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("frame_done seen", 12'(frameDone), 12'h001);
  endtask

  // Pop and compare one observation per clock for a whole frame. Must be
  // called just after the edge that starts the frame's first slot.
  task automatic checkFrame(input string tag);
    obs_t e;
    for (int d = 0; d < ND; d++) begin
      for (int c = 0; c < SD; c++) begin
        @(posedge clk); #1;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s d%0d c%0d scoreboard empty", tag, d, c);
        end else begin
          e = expQ.pop_front();
          checkOutput($sformatf("%s d%0d c%0d", tag, d, c), {an, seg, dp}, e);
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    value      = '0;
    dpIn       = '0;
    blankEn    = '0;
    lzSuppress = 1'b0;
    load       = 1'b0;

    //                value     dpIn     blankEn  lz    d3          d2          d1          d0          expDp
    vecs[0] = {16'h12AF, 4'b0000, 4'b0000, 1'b0, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}, 4'b1111};
    vecs[1] = {16'h0005, 4'b0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100}, 4'b1111};
    vecs[2] = {16'h0005, 4'b0000, 4'b0000, 1'b0, {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100}, 4'b1111};
    vecs[3] = {16'h4321, 4'b0101, 4'b0100, 1'b0, {7'b1001100, 7'b1111111, 7'b0010010, 7'b1001111}, 4'b1110};
    vecs[4] = {16'h0007, 4'b0100, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001111}, 4'b1011};
    vecs[5] = {16'h0B06, 4'b0000, 4'b0000, 1'b1, {7'b1111111, 7'b1100000, 7'b0000001, 7'b0100000}, 4'b1111};
    vecs[6] = {16'hCDE8, 4'b0000, 4'b0000, 1'b1, {7'b0110001, 7'b1000010, 7'b0110000, 7'b0000000}, 4'b1111};
    vecs[7] = {16'h9000, 4'b0000, 4'b0000, 1'b1, {7'b0000100, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111};
    vecs[8] = {16'h0000, 4'b0001, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001}, 4'b1110};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset an",         12'(an),            12'h00F);
    checkOutput("reset seg",        12'(seg),           12'h07F);
    checkOutput("reset dp",         12'(dp),            12'h001);
    checkOutput("reset frame_done", 12'(frameDone),     12'h000);
    checkOutput("reset pending",    12'(dut.pending_q), 12'h000);

    // First frame after reset shows the all-zero shadow starting at digit 0
    rst_n = 1'b1;
    pushFrame({7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111);
    checkFrame("post-reset");

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      waitFrameDone();
      @(posedge clk); #1;
      checkFrame($sformatf("vec%0d", i));
    end

    // Two loads inside one frame: only the last must ever appear
    value      = 16'h1111;
    dpIn       = 4'b0000;
    blankEn    = 4'b0000;
    lzSuppress = 1'b0;
    load       = 1'b1;
    @(posedge clk); #1;
    load       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    value = 16'h2222;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    checkOutput("pending after loads", 12'(dut.pending_q), 12'h001);
    pushFrame({7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 4'b1111);
    pushFrame({7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 4'b1111);
    waitFrameDone();
    @(posedge clk); #1;
    checkFrame("lastwins");
    checkFrame("lastwins2");

    // Load on the frame_done clock goes straight to the display
    waitFrameDone();
    value = 16'h5A5A;
    load  = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    checkOutput("pending after boundary load", 12'(dut.pending_q), 12'h000);
    pushFrame({7'b0100100, 7'b0001000, 7'b0100100, 7'b0001000}, 4'b1111);
    checkFrame("bndload");

    // Reset pulsed mid-slot while digit 0 is lit
    repeat (2) @(posedge clk);
    #1;
    checkOutput("pre-reset an", 12'(an), 12'h00E);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset an",         12'(an),        12'h00F);
    checkOutput("midreset seg",        12'(seg),       12'h07F);
    checkOutput("midreset dp",         12'(dp),        12'h001);
    checkOutput("midreset frame_done", 12'(frameDone), 12'h000);
    checkOutput("midreset cnt",        12'(dut.cnt_q), 12'h000);
    checkOutput("midreset idx",        12'(dut.idx_q), 12'h000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pushFrame({7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111);
    checkFrame("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
